obuf_drain_ctrl: RTL and testbench

//  Read-side master for one OBUF tag: walks a contiguous row range, drives bank read ports, returns DDR beats.
//  - One row = one address read from all NUM_BANKS banks in parallel (ROW_W = NUM_BANKS*READ_WIDTH bits).
//  - Serialises each row into DDR_BANDWIDTH-bit beats on a valid/ready stream toward the store/DDR path.
//  - Handles bank read latency and downstream backpressure without losing data.

---
 rtl/obuf_drain_ctrl_pkg.sv | 25 ++
 rtl/obuf_drain_fifo.sv | 60 ++++++
 rtl/obuf_drain_ctrl.sv | 154 +++++++++++++++
 tb/tb_obuf_drain_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_drain_ctrl_pkg.sv
// Shared types and default geometry for the OBUF read-side drain controller.
package obuf_drain_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEF_NUM_BANKS     = 16;
   localparam int DEF_READ_WIDTH    = 64;
   localparam int DEF_READ_LATENCY  = 1;
   localparam int DEF_DDR_BANDWIDTH = 512;

   localparam int ROW_W      = DEF_NUM_BANKS * DEF_READ_WIDTH;
   localparam int BEATS      = ROW_W / DEF_DDR_BANDWIDTH;
   localparam int FIFO_DEPTH = DEF_READ_LATENCY + 1;

   // Pointer increment for FIFOs whose depth need not be a power of two.
   function automatic int wrap_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/obuf_drain_fifo.sv
// Synchronous row FIFO; head row is presented straight from the storage registers.
module obuf_drain_fifo
   import obuf_drain_ctrl_pkg::*;
#(
   parameter int WIDTH = 1024,
   parameter int DEPTH = 2
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_push,
   input  logic [WIDTH-1:0]               i_din,
   input  logic                           i_pop,
   output logic [WIDTH-1:0]               o_dout,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= PW'(wrap_inc(int'(r_wr_ptr), DEPTH));
         end
         if (w_pop) begin
            r_rd_ptr <= PW'(wrap_inc(int'(r_rd_ptr), DEPTH));
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/obuf_drain_ctrl.sv
// Read-side master for one OBUF tag: issues row reads under a credit limit and
// serialises each returned row into DDR-width beats on a valid/ready stream.
module obuf_drain_ctrl
   import obuf_drain_ctrl_pkg::*;
#(
   parameter int NUM_BANKS       = 16,
   parameter int READ_WIDTH      = 64,
   parameter int READ_ADDR_WIDTH = 8,
   parameter int READ_LATENCY    = 1,
   parameter int DDR_BANDWIDTH   = 512,
   parameter int LEN_WIDTH       = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [READ_ADDR_WIDTH-1:0]           base_addr,
   input  logic [LEN_WIDTH-1:0]                 num_rows,
   output logic                                 busy,
   output logic                                 done,
   output logic [NUM_BANKS-1:0]                 bs_read_req,
   output logic [NUM_BANKS*READ_ADDR_WIDTH-1:0] bs_read_addr,
   input  logic [NUM_BANKS*READ_WIDTH-1:0]      bs_read_data,
   output logic [DDR_BANDWIDTH-1:0]             m_data,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic                                 m_last
);

   localparam int P_ROW_W = NUM_BANKS * READ_WIDTH;
   localparam int P_BEATS = P_ROW_W / DDR_BANDWIDTH;
   localparam int P_DEPTH = READ_LATENCY + 1;
   localparam int CW      = $clog2(P_DEPTH + 1);
   localparam int BW      = (P_BEATS > 1) ? $clog2(P_BEATS) : 1;

   state_t                     r_state;
   logic                       r_busy;
   logic                       r_done;
   logic [READ_ADDR_WIDTH-1:0] r_base;
   logic [LEN_WIDTH-1:0]       r_num;
   logic [LEN_WIDTH-1:0]       r_idx;
   logic [LEN_WIDTH-1:0]       r_rows_out;
   logic [CW-1:0]              r_outst;
   logic [READ_LATENCY-1:0]    r_vld_p;
   logic [BW-1:0]              r_beat;

   logic [P_ROW_W-1:0]         w_head;
   logic [CW-1:0]              w_cnt;
   logic                       w_full;
   logic                       w_empty;
   logic [CW:0]                w_inflight;
   logic                       w_issue;
   logic                       w_ret;
   logic                       w_accept;
   logic                       w_row_end;
   logic                       w_pop;
   logic                       w_last;
   logic [READ_ADDR_WIDTH-1:0] w_addr;

   // Credit: every request in flight already owns a FIFO slot.
   assign w_inflight = {1'b0, r_outst} + {1'b0, w_cnt};
   assign w_issue    = (r_state == ST_RUN) && (w_inflight < (CW+1)'(P_DEPTH)) && !w_full;
   assign w_ret      = r_vld_p[READ_LATENCY-1];
   assign w_addr     = w_issue ? (r_base + r_idx[READ_ADDR_WIDTH-1:0]) : '0;

   assign w_accept  = !w_empty && m_ready;
   assign w_row_end = (r_beat == BW'(P_BEATS - 1));
   assign w_pop     = w_accept && w_row_end;
   assign w_last    = !w_empty && w_row_end && (r_rows_out == r_num - LEN_WIDTH'(1));

   assign bs_read_req  = {NUM_BANKS{w_issue}};
   assign bs_read_addr = {NUM_BANKS{w_addr}};
   assign m_valid      = !w_empty;
   assign m_data       = w_empty ? '0 : w_head[int'(r_beat)*DDR_BANDWIDTH +: DDR_BANDWIDTH];
   assign m_last       = w_last;
   assign busy         = r_busy;
   assign done         = r_done;

   obuf_drain_fifo #(
      .WIDTH (P_ROW_W),
      .DEPTH (P_DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_push  (w_ret),
      .i_din   (bs_read_data),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_cnt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_base     <= '0;
         r_num      <= '0;
         r_idx      <= '0;
         r_rows_out <= '0;
         r_outst    <= '0;
         r_vld_p    <= '0;
         r_beat     <= '0;
      end else begin
         r_vld_p <= (r_vld_p << 1) | READ_LATENCY'(w_issue);
         r_outst <= r_outst + CW'(w_issue) - CW'(w_ret);
         r_done  <= 1'b0;
         if (w_issue) begin
            r_idx <= r_idx + LEN_WIDTH'(1);
         end
         if (w_accept) begin
            r_beat <= w_row_end ? '0 : r_beat + BW'(1);
         end
         if (w_pop) begin
            r_rows_out <= r_rows_out + LEN_WIDTH'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_base     <= base_addr;
                  r_num      <= num_rows;
                  r_idx      <= '0;
                  r_rows_out <= '0;
                  r_beat     <= '0;
                  if (num_rows == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_issue && (r_idx == r_num - LEN_WIDTH'(1))) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_accept && w_last) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// Scoreboard bench for obuf_drain_ctrl: one instance at latency 1, one at latency 3,
// each fed by a behavioural bank model returning address-tagged row data.
module tb_obuf_drain_ctrl;

   localparam int NB = 16;
   localparam int RW = 64;
   localparam int AW = 8;
   localparam int DW = 512;
   localparam int LW = 16;
   localparam int RoW = NB * RW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] salt = 16'h1111;

   logic          start_a = 1'b0, start_b = 1'b0;
   logic [AW-1:0] base_a = '0, base_b = '0;
   logic [LW-1:0] num_a = '0, num_b = '0;
   logic          ready_a = 1'b1, ready_b = 1'b1;
   logic          busy_a, busy_b, done_a, done_b;
   logic [NB-1:0] req_a, req_b;
   logic [NB*AW-1:0] addr_a, addr_b;
   logic [RoW-1:0] rdata_a, rdata_b;
   logic [DW-1:0] mdata_a, mdata_b;
   logic          mvalid_a, mvalid_b, mlast_a, mlast_b;

   logic [AW-1:0] apipe_a;
   logic [AW-1:0] apipe_b [3];

   int n_cmp = 0;
   int n_fail = 0;

   int            exp_addr[$];
   logic [DW-1:0] exp_data[$];
   logic          exp_last[$];
   int            obs_addr[$];
   logic [DW-1:0] obs_data[$];
   logic          obs_last[$];
   int            obs_cyc[$];
   int            first_valid, done_cyc, stall_viol, uni_viol, busy_viol, max_cnt;
   logic          timed_out, done_after;

   always #5 clk = ~clk;

   function automatic logic [RoW-1:0] rowdata(input logic [7:0] a, input logic [15:0] s);
      logic [RoW-1:0] r;
      for (int b = 0; b < NB; b++) begin
         r[b*RW +: RW] = {s, 8'(b), a, 16'(a*7 + b), 8'hC3, 8'(b) ^ a};
      end
      return r;
   endfunction

   // Bank model: data for a request appears READ_LATENCY cycles later.
   always @(posedge clk) begin
      apipe_a    <= addr_a[AW-1:0];
      apipe_b[0] <= addr_b[AW-1:0];
      apipe_b[1] <= apipe_b[0];
      apipe_b[2] <= apipe_b[1];
   end
   assign rdata_a = rowdata(apipe_a, salt);
   assign rdata_b = rowdata(apipe_b[2], salt);

   obuf_drain_ctrl #(
      .NUM_BANKS(NB), .READ_WIDTH(RW), .READ_ADDR_WIDTH(AW),
      .READ_LATENCY(1), .DDR_BANDWIDTH(DW), .LEN_WIDTH(LW)
   ) u_dut1 (
      .clk(clk), .reset(rst_n), .start(start_a), .base_addr(base_a), .num_rows(num_a),
      .busy(busy_a), .done(done_a), .bs_read_req(req_a), .bs_read_addr(addr_a),
      .bs_read_data(rdata_a), .m_data(mdata_a), .m_valid(mvalid_a), .m_ready(ready_a),
      .m_last(mlast_a)
   );

   obuf_drain_ctrl #(
      .NUM_BANKS(NB), .READ_WIDTH(RW), .READ_ADDR_WIDTH(AW),
      .READ_LATENCY(3), .DDR_BANDWIDTH(DW), .LEN_WIDTH(LW)
   ) u_dut3 (
      .clk(clk), .reset(rst_n), .start(start_b), .base_addr(base_b), .num_rows(num_b),
      .busy(busy_b), .done(done_b), .bs_read_req(req_b), .bs_read_addr(addr_b),
      .bs_read_data(rdata_b), .m_data(mdata_b), .m_valid(mvalid_b), .m_ready(ready_b),
      .m_last(mlast_b)
   );

   task automatic push_exp(input logic [7:0] base, input int num);
      logic [RoW-1:0] row;
      logic [7:0] a;
      for (int i = 0; i < num; i++) begin
         a = base + 8'(i);
         exp_addr.push_back(int'(a));
         row = rowdata(a, salt);
         for (int k = 0; k < RoW/DW; k++) begin
            exp_data.push_back(row[k*DW +: DW]);
            exp_last.push_back((i == num - 1) && (k == RoW/DW - 1));
         end
      end
   endtask

   // Drives one transfer and records what the DUT does, cycle by cycle.
   task automatic collect(input bit sel, input logic [7:0] base, input logic [15:0] num,
                          input int rdy_pct, input bit spurious, input int budget);
      logic v, l, r, dn, bz, pv, pr, pl, rq;
      logic [DW-1:0] d, pd;
      logic [NB*AW-1:0] ad;
      logic [NB-1:0] rqv;
      int cnt;
      obs_addr.delete(); obs_data.delete(); obs_last.delete(); obs_cyc.delete();
      first_valid = -1; done_cyc = -1; stall_viol = 0; uni_viol = 0; busy_viol = 0;
      max_cnt = 0; timed_out = 1'b1; done_after = 1'bx;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
      @(negedge clk);
      if (sel) begin start_b = 1'b1; base_b = base; num_b = num; end
      else begin start_a = 1'b1; base_a = base; num_a = num; end
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         r = ($urandom_range(0, 99) < rdy_pct);
         if (sel) begin
            start_b = 1'b0; ready_b = r;
         end else begin
            start_a = (spurious && c == 3);
            if (spurious && c == 3) begin base_a = 8'hAA; num_a = 16'd1; end
            ready_a = r;
         end
         #1;
         v   = sel ? mvalid_b : mvalid_a;
         d   = sel ? mdata_b : mdata_a;
         l   = sel ? mlast_b : mlast_a;
         dn  = sel ? done_b : done_a;
         bz  = sel ? busy_b : busy_a;
         rqv = sel ? req_b : req_a;
         ad  = sel ? addr_b : addr_a;
         cnt = sel ? int'(u_dut3.w_cnt) : int'(u_dut1.w_cnt);
         rq  = |rqv;
         if (rq) begin
            if (rqv != '1) uni_viol++;
            for (int b = 1; b < NB; b++) if (ad[b*AW +: AW] != ad[AW-1:0]) uni_viol++;
            obs_addr.push_back(int'(ad[AW-1:0]));
         end
         if (v && first_valid < 0) first_valid = c;
         if (v && r) begin
            obs_data.push_back(d); obs_last.push_back(l); obs_cyc.push_back(c);
         end
         if (pv && !pr && (!v || d !== pd || l !== pl)) stall_viol++;
         pv = v; pr = r; pd = d; pl = l;
         if (cnt > max_cnt) max_cnt = cnt;
         if (num != 0 && !dn && !bz) busy_viol++;
         if (dn && bz) busy_viol++;
         if (dn) begin
            done_cyc = c; timed_out = 1'b0;
            @(negedge clk); #1;
            done_after = sel ? done_b : done_a;
            break;
         end
      end
      ready_a = 1'b1; ready_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] za, zb;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      za = {busy_a, done_a, |req_a, |addr_a, mvalid_a, |mdata_a, mlast_a};
      zb = {busy_b, done_b, |req_b, |addr_b, mvalid_b, |mdata_b, mlast_b};
      n_cmp++; if (za !== 7'b0) begin n_fail++; $display("FAIL reset_outs_l1: got %b required 0000000", za); end
      n_cmp++; if (zb !== 7'b0) begin n_fail++; $display("FAIL reset_outs_l3: got %b required 0000000", zb); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int e, o, lastc, gaps, c;
      logic [DW-1:0] ed, od;
      logic el, ol;
      salt = 16'hB001;
      push_exp(8'h10, 4);
      collect(1'b0, 8'h10, 16'd4, 100, 1'b0, 100);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL basic_done: got no done required done pulse"); end
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front(); o = (obs_addr.size() > 0) ? obs_addr.pop_front() : -1;
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL basic_addr: got %0h required %0h", o, e); end
      end
      lastc = -1; gaps = 0;
      while (exp_data.size() > 0) begin
         ed = exp_data.pop_front(); el = exp_last.pop_front(); od = 'x; ol = 1'bx;
         if (obs_data.size() > 0) begin
            od = obs_data.pop_front(); ol = obs_last.pop_front(); c = obs_cyc.pop_front();
            if (lastc >= 0 && c != lastc + 1) gaps++;
            lastc = c;
         end
         n_cmp++; if (od !== ed || ol !== el) begin n_fail++; $display("FAIL basic_beat: got %h last %b required %h last %b", od, ol, ed, el); end
      end
      n_cmp++; if (obs_addr.size() + obs_data.size() != 0) begin n_fail++; $display("FAIL basic_extra: got %0d extra items required 0", obs_addr.size() + obs_data.size()); end
      n_cmp++; if (first_valid != 3) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d required 3", first_valid); end
      n_cmp++; if (done_cyc != 11 || done_cyc != lastc + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d (last beat %0d) required 11", done_cyc, lastc); end
      n_cmp++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b required 0", done_after); end
      n_cmp++; if (gaps != 0) begin n_fail++; $display("FAIL basic_throughput: got %0d bubbles required 0", gaps); end
      n_cmp++; if (uni_viol + stall_viol + busy_viol != 0) begin n_fail++; $display("FAIL basic_protocol: got %0d/%0d/%0d required 0/0/0", uni_viol, stall_viol, busy_viol); end
   endtask

   task automatic test_zero_len();
      collect(1'b0, 8'h55, 16'd0, 100, 1'b0, 20);
      n_cmp++; if (done_cyc != 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d required 1", done_cyc); end
      n_cmp++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL zero_reqs: got %0d reqs required 0", obs_addr.size()); end
      n_cmp++; if (first_valid != -1) begin n_fail++; $display("FAIL zero_valid: got m_valid at cycle %0d required never", first_valid); end
      n_cmp++; if (done_after !== 1'b0 || busy_viol != 0) begin n_fail++; $display("FAIL zero_done_busy: got done_after %b busy_viol %0d required 0 0", done_after, busy_viol); end
   endtask

   task automatic test_wrap();
      int e, o, lastc, c;
      logic [DW-1:0] ed, od;
      logic el, ol;
      salt = 16'hC0DE;
      push_exp(8'hFE, 3);
      collect(1'b0, 8'hFE, 16'd3, 100, 1'b0, 100);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL wrap_done: got no done required done pulse"); end
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front(); o = (obs_addr.size() > 0) ? obs_addr.pop_front() : -1;
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL wrap_addr: got %0h required %0h", o, e); end
      end
      lastc = -1;
      while (exp_data.size() > 0) begin
         ed = exp_data.pop_front(); el = exp_last.pop_front(); od = 'x; ol = 1'bx;
         if (obs_data.size() > 0) begin
            od = obs_data.pop_front(); ol = obs_last.pop_front(); c = obs_cyc.pop_front(); lastc = c;
         end
         n_cmp++; if (od !== ed || ol !== el) begin n_fail++; $display("FAIL wrap_beat: got %h last %b required %h last %b", od, ol, ed, el); end
      end
      n_cmp++; if (obs_addr.size() + obs_data.size() != 0 || done_cyc != lastc + 1) begin n_fail++; $display("FAIL wrap_tail: got %0d extra, done %0d required 0 extra, done %0d", obs_addr.size() + obs_data.size(), done_cyc, lastc + 1); end
   endtask

   task automatic test_backpressure();
      int e, o, lastc, c;
      logic [DW-1:0] ed, od;
      logic el, ol;
      salt = 16'hBEEF;
      push_exp(8'h20, 6);
      collect(1'b0, 8'h20, 16'd6, 30, 1'b1, 600);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL bp_done: got no done required done pulse"); end
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front(); o = (obs_addr.size() > 0) ? obs_addr.pop_front() : -1;
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL bp_addr: got %0h required %0h", o, e); end
      end
      lastc = -1;
      while (exp_data.size() > 0) begin
         ed = exp_data.pop_front(); el = exp_last.pop_front(); od = 'x; ol = 1'bx;
         if (obs_data.size() > 0) begin
            od = obs_data.pop_front(); ol = obs_last.pop_front(); c = obs_cyc.pop_front(); lastc = c;
         end
         n_cmp++; if (od !== ed || ol !== el) begin n_fail++; $display("FAIL bp_beat: got %h last %b required %h last %b", od, ol, ed, el); end
      end
      n_cmp++; if (obs_addr.size() + obs_data.size() != 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra items required 0", obs_addr.size() + obs_data.size()); end
      n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d stall changes required 0", stall_viol); end
      n_cmp++; if (max_cnt > 2) begin n_fail++; $display("FAIL bp_fifo_count: got max %0d required <= 2", max_cnt); end
      n_cmp++; if (done_cyc != lastc + 1 || uni_viol + busy_viol != 0) begin n_fail++; $display("FAIL bp_done_cycle: got done %0d uni %0d busy %0d required done %0d 0 0", done_cyc, uni_viol, busy_viol, lastc + 1); end
   endtask

   task automatic test_latency();
      int e, o, lastc, gaps, c;
      logic [DW-1:0] ed, od;
      logic el, ol;
      salt = 16'h3A3A;
      push_exp(8'h30, 5);
      collect(1'b1, 8'h30, 16'd5, 100, 1'b0, 100);
      n_cmp++; if (first_valid != 5) begin n_fail++; $display("FAIL lat3_first_valid: got cycle %0d required 5", first_valid); end
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front(); o = (obs_addr.size() > 0) ? obs_addr.pop_front() : -1;
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL lat3_addr: got %0h required %0h", o, e); end
      end
      lastc = -1; gaps = 0;
      while (exp_data.size() > 0) begin
         ed = exp_data.pop_front(); el = exp_last.pop_front(); od = 'x; ol = 1'bx;
         if (obs_data.size() > 0) begin
            od = obs_data.pop_front(); ol = obs_last.pop_front(); c = obs_cyc.pop_front();
            if (lastc >= 0 && c != lastc + 1) gaps++;
            lastc = c;
         end
         n_cmp++; if (od !== ed || ol !== el) begin n_fail++; $display("FAIL lat3_beat: got %h last %b required %h last %b", od, ol, ed, el); end
      end
      n_cmp++; if (gaps != 0) begin n_fail++; $display("FAIL lat3_throughput: got %0d bubbles required 0", gaps); end
      n_cmp++; if (max_cnt > 4 || done_cyc != lastc + 1) begin n_fail++; $display("FAIL lat3_tail: got max count %0d done %0d required <=4 done %0d", max_cnt, done_cyc, lastc + 1); end
   endtask

   task automatic test_abort();
      int e, o;
      logic [DW-1:0] ed, od;
      logic el, ol;
      logic [6:0] za;
      salt = 16'hDEAD;
      @(negedge clk);
      start_a = 1'b1; base_a = 8'h40; num_a = 16'd8;
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); #1;
      za = {busy_a, done_a, |req_a, |addr_a, mvalid_a, |mdata_a, mlast_a};
      n_cmp++; if (za !== 7'b0) begin n_fail++; $display("FAIL abort_outs: got %b required 0000000", za); end
      rst_n = 1'b1;
      salt = 16'hF00D;
      push_exp(8'h80, 2);
      collect(1'b0, 8'h80, 16'd2, 100, 1'b0, 100);
      n_cmp++; if (first_valid != 3 || timed_out) begin n_fail++; $display("FAIL abort_restart: got first valid %0d timeout %b required 3 0", first_valid, timed_out); end
      while (exp_addr.size() > 0) begin
         e = exp_addr.pop_front(); o = (obs_addr.size() > 0) ? obs_addr.pop_front() : -1;
         n_cmp++; if (o !== e) begin n_fail++; $display("FAIL abort_addr: got %0h required %0h", o, e); end
      end
      while (exp_data.size() > 0) begin
         ed = exp_data.pop_front(); el = exp_last.pop_front(); od = 'x; ol = 1'bx;
         if (obs_data.size() > 0) begin od = obs_data.pop_front(); ol = obs_last.pop_front(); end
         n_cmp++; if (od !== ed || ol !== el) begin n_fail++; $display("FAIL abort_beat: got %h last %b required %h last %b", od, ol, ed, el); end
      end
      n_cmp++; if (obs_addr.size() + obs_data.size() != 0) begin n_fail++; $display("FAIL abort_extra: got %0d extra items required 0", obs_addr.size() + obs_data.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_wrap();
      test_backpressure();
      test_latency();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
